// File: rtl/kirby_anim_pkg.sv
// kirby_anim_pkg
// Shared definitions for the Kirby sprite animation path: the action
// indices, the per-action frame counts (also read by the sprite-sheet
// frame mapper), which actions play once, and the sequencer state type.
package kirby_anim_pkg;

    localparam logic [2:0] NUM_ACTIONS = 3'd3;

    localparam logic [2:0] ACT_IDLE   = 3'd0;
    localparam logic [2:0] ACT_WALK   = 3'd1;
    localparam logic [2:0] ACT_INHALE = 3'd2;

    // Frames per action, indexed by action. 10-bit entries to match the mapper.
    localparam logic [9:0] FRAME_NUMBER [int'(NUM_ACTIONS)] = '{10'd2, 10'd10, 10'd10};

    // Bit n set: action n plays once and then returns to idle.
    localparam logic [2:0] ONESHOT_MASK = 3'b100;

    typedef enum logic [1:0] {
        S_LOOP,
        S_ONESHOT,
        S_DONE
    } anim_state_t;

    // Frame count of an action, truncated to the 4-bit frame index width.
    // Unknown actions report the idle count; callers map them beforehand.
    function automatic logic [3:0] frame_count(input logic [2:0] act);
        logic [9:0] n;
        n = FRAME_NUMBER[0];
        case (act)
            ACT_WALK:   n = FRAME_NUMBER[1];
            ACT_INHALE: n = FRAME_NUMBER[2];
            default:    n = FRAME_NUMBER[0];
        endcase
        return n[3:0];
    endfunction

    function automatic logic is_oneshot(input logic [2:0] act);
        logic [7:0] m;
        m = {5'b0, ONESHOT_MASK};
        return m[act];
    endfunction

endpackage

// File: rtl/kirby_anim_sequencer_tick_div.sv
// anim_tick_divider
// Counts frame_tick pulses 0..TICKS_PER_FRAME-1 and emits a one-cycle
// advance pulse on the pulse that lands on the terminal count.
// Ports:
//   Clk, Reset_n  - clock, async active-low reset
//   frame_tick    - one pulse per video frame
//   pause         - hold the count, ignore frame_tick
//   clear         - reload 0 and suppress advance (a new animation starts)
//   advance       - move to the next sprite frame this cycle
module anim_tick_divider #(
    parameter int TICKS_PER_FRAME = 6
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_tick,
    input  logic pause,
    input  logic clear,
    output logic advance
);

    localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [TW-1:0] TERM = TW'(TICKS_PER_FRAME - 1);

    logic [TW-1:0] r_tick;
    logic          w_tick_en;
    logic          w_term;

    assign w_tick_en = frame_tick & ~pause & ~clear;
    assign w_term    = (r_tick == TERM);
    assign advance   = w_tick_en & w_term;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tick <= '0;
        end else if (clear) begin
            r_tick <= '0;
        end else if (w_tick_en) begin
            r_tick <= w_term ? '0 : r_tick + TW'(1);
        end
    end

endmodule

// File: rtl/kirby_anim_sequencer.sv
// kirby_anim_sequencer
// Accepts action requests, holds each sprite frame for TICKS_PER_FRAME
// video frames and walks the frame index through the action's frame count,
// looping or playing once.
// Ports:
//   Clk, Reset_n                - clock, async active-low reset
//   frame_tick, pause           - video frame pulse, animation freeze
//   req_valid/req_action/req_ready - action request handshake
//   character_action_idx        - current action to the frame mapper
//   character_action_frame_idx  - current frame within that action
//   anim_done                   - one-cycle pulse when a one-shot ends
//
// state     | meaning
// S_LOOP    | looping action playing, requests accepted
// S_ONESHOT | one-shot playing, requests held off
// S_DONE    | one-shot finished, single cycle, reload idle
module kirby_anim_sequencer
    import kirby_anim_pkg::*;
#(
    parameter int         TICKS_PER_FRAME = 6,
    parameter logic [2:0] IDLE_ACTION     = ACT_IDLE
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       pause,
    input  logic       req_valid,
    input  logic [2:0] req_action,
    output logic       req_ready,
    output logic [2:0] character_action_idx,
    output logic [3:0] character_action_frame_idx,
    output logic       anim_done
);

    anim_state_t r_state, w_state_nxt;
    logic [2:0]  r_action, w_action_nxt;
    logic [3:0]  r_frame, w_frame_nxt;
    logic [2:0]  w_req_act;
    logic        w_load;
    logic        w_clear;
    logic        w_advance;
    logic        w_last;

    assign w_req_act = (req_action >= NUM_ACTIONS) ? IDLE_ACTION : req_action;

    // Re-requesting the running looping action is a no-op, so it must not
    // restart the counters.
    assign w_load  = (r_state == S_LOOP) && req_valid &&
                     ((w_req_act != r_action) || is_oneshot(w_req_act));
    assign w_clear = w_load || (r_state == S_DONE);
    assign w_last  = (r_frame == frame_count(r_action) - 4'd1);

    anim_tick_divider #(
        .TICKS_PER_FRAME (TICKS_PER_FRAME)
    ) u_tick_div (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .pause      (pause),
        .clear      (w_clear),
        .advance    (w_advance)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_action_nxt = r_action;
        w_frame_nxt  = r_frame;
        case (r_state)
            S_LOOP: begin
                if (w_load) begin
                    w_action_nxt = w_req_act;
                    w_frame_nxt  = 4'd0;
                    if (is_oneshot(w_req_act)) w_state_nxt = S_ONESHOT;
                end else if (w_advance) begin
                    w_frame_nxt = w_last ? 4'd0 : r_frame + 4'd1;
                end
            end
            S_ONESHOT: begin
                if (w_advance) begin
                    if (w_last) w_state_nxt = S_DONE;
                    else        w_frame_nxt = r_frame + 4'd1;
                end
            end
            S_DONE: begin
                w_action_nxt = IDLE_ACTION;
                w_frame_nxt  = 4'd0;
                w_state_nxt  = S_LOOP;
            end
            default: begin
                w_state_nxt = S_LOOP;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_LOOP;
            r_action <= IDLE_ACTION;
            r_frame  <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_action <= w_action_nxt;
            r_frame  <= w_frame_nxt;
        end
    end

    assign req_ready                  = (r_state == S_LOOP);
    assign anim_done                  = (r_state == S_DONE);
    assign character_action_idx       = r_action;
    assign character_action_frame_idx = r_frame;

endmodule

// File: tb/tb_kirby_anim_sequencer.sv
module tb_kirby_anim_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_action = 3'd0;
    logic       req_ready;
    logic [2:0] character_action_idx;
    logic [3:0] character_action_frame_idx;
    logic       anim_done;

    int n_checks = 0;
    int n_pass = 0;
    int done_count = 0;

    kirby_anim_sequencer #(
        .TICKS_PER_FRAME (2),
        .IDLE_ACTION     (3'd0)
    ) dut (
        .Clk                        (Clk),
        .Reset_n                    (Reset_n),
        .frame_tick                 (frame_tick),
        .pause                      (pause),
        .req_valid                  (req_valid),
        .req_action                 (req_action),
        .req_ready                  (req_ready),
        .character_action_idx       (character_action_idx),
        .character_action_frame_idx (character_action_frame_idx),
        .anim_done                  (anim_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (anim_done === 1'b1) done_count++;

    typedef struct {
        logic       tick;
        logic       pse;
        logic       vld;
        logic [2:0] act;
        logic [2:0] e_act;
        logic [3:0] e_frame;
        logic       e_rdy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic t, input logic p, input logic v,
                                input logic [2:0] a, input logic [2:0] ea,
                                input logic [3:0] ef, input logic er);
        vec_t x;
        x.tick = t; x.pse = p; x.vld = v; x.act = a;
        x.e_act = ea; x.e_frame = ef; x.e_rdy = er;
        return x;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    endtask

    task automatic check_outs(input string tag, input int idx, input logic [2:0] ea,
                              input logic [3:0] ef, input logic er, input logic ed);
        check({tag, ".action"}, idx, 32'(character_action_idx), 32'(ea));
        check({tag, ".frame"},  idx, 32'(character_action_frame_idx), 32'(ef));
        check({tag, ".ready"},  idx, 32'(req_ready), 32'(er));
        check({tag, ".done"},   idx, 32'(anim_done), 32'(ed));
    endtask

    // Drive one cycle of inputs, sample 1 ns after the edge that consumed them.
    task automatic cycle(input logic t, input logic p, input logic v, input logic [2:0] a);
        frame_tick = t; pause = p; req_valid = v; req_action = a;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0; pause = 1'b0; req_valid = 1'b0;
    endtask

    logic [3:0] idle_exp [8]  = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
    logic [3:0] walk_exp [20] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5,
                                  4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd0};
    logic [3:0] shot_exp [20] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5,
                                  4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd8, 4'd8, 4'd9, 4'd9, 4'd9};

    initial begin
        int d0;

        // Idle loop from reset, TICKS_PER_FRAME = 2.
        for (int i = 0; i < 8; i++) vq.push_back(mk(1, 0, 0, 0, 0, idle_exp[i], 1));
        // Three more ticks leave the tick counter at 1.
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1));
        // Switch to walk: frame 0, tick cleared.
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 1));
        for (int i = 0; i < 20; i++) vq.push_back(mk(1, 0, 0, 0, 1, walk_exp[i], 1));
        for (int i = 0; i < 5; i++)  vq.push_back(mk(1, 0, 0, 0, 1, walk_exp[i], 1));
        // Re-request walk: no restart, and a terminal tick still advances.
        vq.push_back(mk(0, 0, 1, 1, 1, 2, 1));
        vq.push_back(mk(1, 0, 1, 1, 1, 3, 1));
        vq.push_back(mk(1, 0, 0, 0, 1, 3, 1));
        // Idle request on the terminal tick: request wins, counters zeroed.
        vq.push_back(mk(1, 0, 1, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 1, 1));
        // Pause with ticks: frame frozen, request still taken.
        vq.push_back(mk(1, 1, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 1, 0, 0, 0, 1, 1));
        vq.push_back(mk(1, 1, 1, 1, 1, 0, 1));
        vq.push_back(mk(1, 1, 0, 0, 1, 0, 1));
        vq.push_back(mk(1, 1, 0, 0, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 1, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 1, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 1));

        repeat (3) @(posedge Clk);
        #1;
        check_outs("reset", 0, 3'd0, 4'd0, 1'b1, 1'b0);
        Reset_n = 1'b1;

        foreach (vq[i]) begin
            cycle(vq[i].tick, vq[i].pse, vq[i].vld, vq[i].act);
            check_outs("vec", i, vq[i].e_act, vq[i].e_frame, vq[i].e_rdy, 1'b0);
        end

        // One-shot inhale with a walk request held throughout.
        d0 = done_count;
        cycle(0, 0, 1, 3'd2);
        check_outs("shot_start", 0, 3'd2, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 1, 3'd1);
            check_outs("shot", i, 3'd2, shot_exp[i], 1'b0, (i == 19) ? 1'b1 : 1'b0);
        end
        cycle(0, 0, 1, 3'd1);
        check_outs("shot_idle", 0, 3'd0, 4'd0, 1'b1, 1'b0);
        cycle(0, 0, 1, 3'd1);
        check_outs("shot_pending", 0, 3'd1, 4'd0, 1'b1, 1'b0);
        check("shot_done_pulses", 0, 32'(done_count - d0), 32'd1);

        // Reset in the middle of a one-shot.
        cycle(0, 0, 1, 3'd2);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 3'd0);
        check_outs("mid_shot", 0, 3'd2, 4'd5, 1'b0, 1'b0);
        d0 = done_count;
        Reset_n = 1'b0;
        #2;
        check_outs("async_reset", 0, 3'd0, 4'd0, 1'b1, 1'b0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 24; i++) cycle(1, 0, 0, 3'd0);
        check("reset_no_done", 0, 32'(done_count - d0), 32'd0);
        check_outs("after_reset", 0, 3'd0, 4'd0, 1'b1, 1'b0);

        // Out-of-range requests map to idle.
        cycle(0, 0, 1, 3'd1);
        check_outs("oor_walk", 0, 3'd1, 4'd0, 1'b1, 1'b0);
        cycle(1, 0, 0, 3'd0);
        cycle(1, 0, 0, 3'd0);
        check_outs("oor_walk_adv", 0, 3'd1, 4'd1, 1'b1, 1'b0);
        cycle(0, 0, 1, 3'd6);
        check_outs("oor_6", 0, 3'd0, 4'd0, 1'b1, 1'b0);
        cycle(0, 0, 1, 3'd7);
        check_outs("oor_7", 0, 3'd0, 4'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/kirby_anim_sequencer.md
# kirby_anim_sequencer

Sequences the Kirby sprite animation. Accepts action requests from the game-logic block and holds each animation frame for a programmable number of video frames. Walks the frame index through the per-action frame count, looping or playing once as required. Drives `character_action_idx` / `character_action_frame_idx` into the sprite-sheet frame mapper.

## Interface

Parameters:
- `TICKS_PER_FRAME`, 6, video frames each sprite frame is held (≥1)
- `IDLE_ACTION`, 0, action the block returns to after a one-shot and after reset

Ports:
- `Clk` in 1 — system clock, single domain
- `Reset_n` in 1 — asynchronous, active-low reset
- `frame_tick` in 1 — one-`Clk`-cycle pulse per video frame (vsync edge, already synchronised)
- `pause` in 1 — freeze animation counters while high
- `req_valid` in 1 — action request present
- `req_action` in 3 — requested action index
- `req_ready` out 1 — request accepted this cycle when `req_valid & req_ready`
- `character_action_idx` out 3 — current action to frame mapper
- `character_action_frame_idx` out 4 — current frame within action
- `anim_done` out 1 — one-cycle pulse when a one-shot action finishes

## Operation

- Action table, from the package: action 0 idle (2 frames, loop), action 1 walk (10 frames, loop), action 2 inhale (10 frames, one-shot).
- Indices ≥3 are accepted and treated as `IDLE_ACTION`.
- The tick counter counts `frame_tick` pulses from 0 to `TICKS_PER_FRAME-1`.
  - On a pulse at the terminal count: tick counter → 0 and the frame advances.
  - Frame wraps from `FRAME_NUMBER[act]-1` to 0.
- FSM states:
  - **S_LOOP** (reset state):
    - `req_ready`=1.
    - Accepted looping action different from the current one: switch action, frame=0, tick=0.
    - Accepted request equal to the current looping action: no effect, no restart.
    - Accepted one-shot action: load it with frame=0, tick=0, go to S_ONESHOT.
  - **S_ONESHOT**:
    - `req_ready`=0; the requester holds its request.
    - The frame advances as above.
    - When advancing from the last frame: no wrap; go to S_DONE with frame held at last.
  - **S_DONE**:
    - Lasts one cycle. `anim_done`=1, `req_ready`=0.
    - Load `IDLE_ACTION`, frame=0, tick=0, go to S_LOOP.
- `pause`=1: tick counter and frame hold and `frame_tick` pulses are ignored. Requests are still accepted in S_LOOP. S_DONE completes normally.
- Simultaneous accept and terminal `frame_tick`: the request wins. Counters load 0; no advance is applied.
- Width rules:
  - Tick counter width is `$clog2(TICKS_PER_FRAME)`, minimum 1 bit.
  - Frame compare is against the 10-bit table entry truncated to 4 bits.
  - All frame counts are ≤15.

## Timing

- All outputs are registered. `req_ready` and `anim_done` are decoded from the state register, glitch-free.
- Reset values: state S_LOOP, `character_action_idx`=`IDLE_ACTION`, `character_action_frame_idx`=0, tick=0, `req_ready`=1, `anim_done`=0.
- `Reset_n` asserted mid-animation returns everything to reset values immediately. This includes abandoning a one-shot without `anim_done`.
- Request accepted at edge k: outputs show the new action, frame 0 after edge k.
- Frame advance: the output changes on the edge that samples the terminal `frame_tick`.
- A one-shot lasts 10·`TICKS_PER_FRAME` ticks from acceptance. `anim_done` goes high the cycle after the terminal tick on frame 9. Idle frame 0 appears one cycle later.
- Tick-to-output latency is 1 cycle. There is no other pipelining.

## Structure

- `kirby_anim_pkg` contains:
  - `NUM_ACTIONS`=3 and action constants `ACT_IDLE`/`ACT_WALK`/`ACT_INHALE`
  - `FRAME_NUMBER` table `{2,10,10}` (10-bit entries, shared with the frame mapper)
  - `ONESHOT_MASK`=3'b100
  - the `anim_state_t` enum {S_LOOP, S_ONESHOT, S_DONE}
- One sub-module, `anim_tick_divider`:
  - Inputs: `Clk`, `Reset_n`, `frame_tick`, `pause`, `clear`.
  - Output: `advance` pulse.
  - Parameter: `TICKS_PER_FRAME`.
- The top level holds the FSM, action/frame registers and table lookup.

## Test plan

- **Reset/idle loop:** `TICKS_PER_FRAME`=2, hold `Reset_n` low, release, send 8 `frame_tick` → frame sequence 0,0,1,1,0,0,1,1; action stays 0; `req_ready`=1.
- **Walk switch and wrap:** request 1 after 3 ticks → next cycle action=1, frame=0. After 20 ticks frame wraps 9→0. Re-requesting 1 mid-animation does not reset the frame.
- **One-shot inhale:** request 2 → `req_ready` drops next cycle. A held request 1 is not accepted. After 20 ticks, `anim_done` pulses exactly once, action=0, frame=0, and the pending request 1 is accepted the following cycle.
- **Simultaneous events:** request 1 on the same cycle as the terminal tick → frame=0, tick=0, no advance. With `pause`=1 for 5 ticks the frame is unchanged, and a request during pause is still accepted.
- **Reset mid-one-shot:** assert `Reset_n` low at inhale frame 5 → outputs 0/0 asynchronously, `anim_done` never pulses. Out-of-range request 6 → treated as idle.
